// File: rtl/load_store_unit.sv
// Load/store unit: queues execute-stage requests, performs one single-cycle
// memory access per request and returns a registered response.
module load_store_unit #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter logic [7:0]  RO_BASE    = 8'hF0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_base,
    input  logic [7:0] req_offset,
    input  logic [7:0] req_wdata,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [7:0] resp_data,
    output logic       resp_write,
    output logic       resp_fault,
    output logic       busy,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_address,
    output logic [7:0] mem_write_data,
    input  logic [7:0] mem_read_data
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } req_t;

    state_t        state, state_nxt;
    req_t          fifo_mem [FIFO_DEPTH];
    req_t          op;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop;

    assign full      = (count == (PW+1)'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign req_ready = !full;
    assign push      = req_valid && !full;

    assign resp_valid = (state == RESP);
    assign busy       = (state != IDLE) || !empty;

    // Request queue storage: effective address formed at push time (wraps mod 256)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{write: req_write,
                                   addr:  req_base + req_offset,
                                   wdata: req_wdata};
        end
    end

    // Request queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // FSM next state, queue pop and memory strobes; strobes are masked by reset
    always_comb begin
        state_nxt      = state;
        pop            = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_address    = op.addr;
                mem_write_data = op.wdata;
                mem_read       = !op.write && !reset;
                mem_write      = op.write && (op.addr < RO_BASE) && !reset;
                state_nxt      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    if (!empty) begin
                        pop       = 1'b1;
                        state_nxt = ACCESS;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operation register and registered response fields
    always_ff @(posedge clk) begin
        if (reset) begin
            op         <= '0;
            resp_data  <= '0;
            resp_write <= 1'b0;
            resp_fault <= 1'b0;
        end else begin
            if (pop) op <= fifo_mem[rd_ptr];
            if (state == ACCESS) begin
                resp_write <= op.write;
                resp_data  <= op.write ? 8'h00 : mem_read_data;
                resp_fault <= op.write && (op.addr >= RO_BASE);
            end else if (state == RESP && resp_ready) begin
                resp_data  <= '0;
                resp_write <= 1'b0;
                resp_fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural data memory.
module tb_load_store_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_write;
    logic [7:0] req_base, req_offset, req_wdata;
    logic       resp_valid, resp_ready;
    logic [7:0] resp_data;
    logic       resp_write, resp_fault, busy;
    logic       mem_read, mem_write;
    logic [7:0] mem_address, mem_write_data, mem_read_data;

    logic [7:0] mem [256];
    bit         mem_init  = 1'b0;
    int         wr_cycles = 0;
    logic [7:0] last_waddr, last_raddr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.FIFO_DEPTH(2), .RO_BASE(8'hF0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_base(req_base), .req_offset(req_offset), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_write(resp_write), .resp_fault(resp_fault), .busy(busy),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Data memory: preload mem[i] = i ^ A5 except mem[04] = 12; commit writes on posedge
    assign mem_read_data = mem_read ? mem[mem_address] : 8'h00;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
            mem[4]   <= 8'h12;
            mem_init <= 1'b1;
        end else if (mem_write) begin
            mem[mem_address] <= mem_write_data;
            wr_cycles        <= wr_cycles + 1;
            last_waddr       <= mem_address;
        end
        if (mem_read) last_raddr <= mem_address;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait for its response; entered and left at a negedge
    task automatic do_op(input logic w, input logic [7:0] b, input logic [7:0] o,
                         input logic [7:0] d, input string tag,
                         output logic [7:0] rd, output logic rw, output logic rf);
        int n;
        req_write  = w;
        req_base   = b;
        req_offset = o;
        req_wdata  = d;
        req_valid  = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_resp_seen"}, resp_valid, 1);
        rd = resp_data;
        rw = resp_write;
        rf = resp_fault;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       rw, rf;
        int         wr0, n;
        logic [7:0] exp_q [3];

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_base = '0; req_offset = '0; req_wdata = '0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_mem_address", mem_address, 8'h00);
        chk("rst_resp_data", resp_data, 8'h00);
        reset = 1'b0;
        @(negedge clk);

        // 5: load 04 right after reset; exact latency accept c0 -> resp c3
        req_write = 1'b0; req_base = 8'h04; req_offset = 8'h00; req_valid = 1'b1;
        chk("t5_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t5_c1_resp_valid", resp_valid, 0);
        chk("t5_c1_busy", busy, 1);
        @(negedge clk);
        chk("t5_c2_mem_read", mem_read, 1);
        chk("t5_c2_mem_address", mem_address, 8'h04);
        chk("t5_c2_resp_valid", resp_valid, 0);
        @(negedge clk);
        chk("t5_c3_resp_valid", resp_valid, 1);
        chk("t5_c3_resp_data", resp_data, 8'h12);
        chk("t5_c3_resp_write", resp_write, 0);
        chk("t5_c3_mem_read", mem_read, 0);
        @(negedge clk);
        chk("t5_after_resp_valid", resp_valid, 0);
        chk("t5_after_busy", busy, 0);

        // 1: store 10+03 <- 5A, then load it back
        wr0 = wr_cycles;
        do_op(1'b1, 8'h10, 8'h03, 8'h5A, "t1_st", rd, rw, rf);
        chk("t1_st_write", rw, 1);
        chk("t1_st_fault", rf, 0);
        chk("t1_st_data", rd, 8'h00);
        chk("t1_st_wr_cycles", wr_cycles - wr0, 1);
        chk("t1_st_waddr", last_waddr, 8'h13);
        chk("t1_mem13", mem[8'h13], 8'h5A);
        do_op(1'b0, 8'h13, 8'h00, 8'h00, "t1_ld", rd, rw, rf);
        chk("t1_ld_data", rd, 8'h5A);
        chk("t1_ld_write", rw, 0);

        // 2: address wrap FE+04 = 02
        do_op(1'b0, 8'hFE, 8'h04, 8'h00, "t2_ld", rd, rw, rf);
        chk("t2_raddr", last_raddr, 8'h02);
        chk("t2_data", rd, 8'hA7);

        // 3: store into protected region faults, load from it still works
        wr0 = wr_cycles;
        do_op(1'b1, 8'hF0, 8'h05, 8'hAA, "t3_st", rd, rw, rf);
        chk("t3_st_fault", rf, 1);
        chk("t3_st_write", rw, 1);
        chk("t3_st_wr_cycles", wr_cycles - wr0, 0);
        do_op(1'b0, 8'hF5, 8'h00, 8'h00, "t3_ld", rd, rw, rf);
        chk("t3_ld_data", rd, 8'h50);
        chk("t3_ld_fault", rf, 0);

        // 4: back-pressure, four back-to-back loads with resp_ready low
        resp_ready = 1'b0;
        req_write = 1'b0; req_offset = 8'h00; req_valid = 1'b1;
        req_base = 8'h30; chk("t4_ready0", req_ready, 1); @(negedge clk);
        req_base = 8'h31; chk("t4_ready1", req_ready, 1); @(negedge clk);
        req_base = 8'h32; chk("t4_ready2", req_ready, 1); @(negedge clk);
        req_base = 8'h33; chk("t4_ready3", req_ready, 0); @(negedge clk);
        chk("t4_ready3_hold", req_ready, 0);
        chk("t4_hold_valid", resp_valid, 1);
        chk("t4_hold_data", resp_data, 8'h95);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        exp_q[0] = 8'h95; exp_q[1] = 8'h94; exp_q[2] = 8'h97;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!resp_valid && n < 20) begin @(negedge clk); n++; end
            chk($sformatf("t4_resp%0d_seen", k), resp_valid, 1);
            chk($sformatf("t4_resp%0d_data", k), resp_data, exp_q[k]);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("t4_no_fourth", resp_valid, 0);
        chk("t4_idle_busy", busy, 0);

        // 6: reset during ACCESS of a store to 20
        wr0 = wr_cycles;
        req_write = 1'b1; req_base = 8'h20; req_offset = 8'h00; req_wdata = 8'h77;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("t6_access_strobe", mem_write, 1);
        chk("t6_access_addr", mem_address, 8'h20);
        reset = 1'b1;
        #1;
        chk("t6_reset_strobe", mem_write, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_resp_valid", resp_valid, 0);
        chk("t6_mem20", mem[8'h20], 8'h85);
        chk("t6_wr_cycles", wr_cycles - wr0, 0);
        chk("t6_mem_address", mem_address, 8'h00);
        @(negedge clk);
        chk("t6_busy_later", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
